// File: rtl/rsh1_ctrl_pkg.sv
// Shared definitions for the sequential RSH1 coefficient multiplier:
// FSM state encoding, data width and the counter-width helper.
package rsh1_ctrl_pkg;

    localparam int WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/constant_multiplier_16bit_RSH1.sv
// 16-bit arithmetic right shift by one: sign-replicating, floor rounding.
module constant_multiplier_16bit_RSH1 (
    input  logic [15:0] in_data,
    output logic [15:0] out_data
);

    assign out_data = {in_data[15], in_data[15:1]};

endmodule

// File: rtl/rsh1_coeff_mult_ctrl.sv
// Sequential fractional multiplier out = in * coeff (unsigned Q0.CBITS), one RSH1 cell
// reused over CBITS cycles. Optional macro RSH1_CTRL_EARLY_DONE_EN enables early exit.
module rsh1_coeff_mult_ctrl
    import rsh1_ctrl_pkg::*;
#(
    parameter int CBITS = 8,
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CBITS-1:0]  coeff,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  out_data
);

    localparam int CNT_W = clog2(CBITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CBITS - 1);

    state_t                  state;
    logic signed [15:0]      x;
    logic signed [15:0]      x_sh;
    logic signed [16:0]      acc;
    logic signed [16:0]      acc_next;
    logic [CBITS-1:0]        coeff_sr;
    logic [CNT_W-1:0]        cnt;
    logic                    last;

    constant_multiplier_16bit_RSH1 u_rsh1 (
        .in_data  (x),
        .out_data (x_sh)
    );

    always_comb begin
        acc_next = acc;
        if (coeff_sr[CBITS-1]) begin
            acc_next = acc + $signed({x_sh[15], x_sh});
        end
`ifdef RSH1_CTRL_EARLY_DONE_EN
        // Stop as soon as no set coefficient bits remain to be consumed.
        last = ((coeff_sr << 1) == '0) || (cnt == CNT_LAST);
`else
        last = (cnt == CNT_LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_data <= '0;
            x        <= '0;
            acc      <= '0;
            cnt      <= '0;
            coeff_sr <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        x        <= $signed(in_data[15:0]);
                        coeff_sr <= coeff;
                        acc      <= '0;
                        cnt      <= '0;
`ifdef RSH1_CTRL_EARLY_DONE_EN
                        if (coeff == '0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            out_data <= '0;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
`else
                        state <= S_RUN;
                        busy  <= 1'b1;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    x        <= x_sh;
                    acc      <= acc_next;
                    coeff_sr <= coeff_sr << 1;
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        out_data <= acc_next[15:0];
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsh1_coeff_mult_ctrl.sv
// Bench for rsh1_coeff_mult_ctrl (CBITS=8, default build): directed and random
// operations against a floor-division reference model.
module tb_rsh1_coeff_mult_ctrl;

    localparam int CBITS = 8;
    localparam int LAT   = CBITS + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [15:0]       in_data;
    logic [CBITS-1:0]  coeff;
    logic              busy;
    logic              done;
    logic [15:0]       out_data;

    int checks;
    int failures;

    rsh1_coeff_mult_ctrl #(.CBITS(CBITS), .WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .coeff    (coeff),
        .busy     (busy),
        .done     (done),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Sum of floor(a / 2^k) over the coefficient bits weighing 2^-k.
    function automatic int model(input int a, input int c);
        int s;
        s = 0;
        for (int k = 1; k <= CBITS; k++) begin
            if (((c >> (CBITS - k)) & 1) == 1) s = s + floor_div(a, 1 << k);
        end
        return s;
    endfunction

    // Pulse start for one cycle, then wait for done; lat counts falling edges
    // after the accepting edge up to the one where done is seen (0 = timeout).
    task automatic do_op(input logic [15:0] a, input logic [CBITS-1:0] c,
                         output logic [15:0] res, output int lat, output int bcnt);
        @(negedge clk);
        in_data = a;
        coeff   = c;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        res   = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                res = out_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in_data = '0;
        coeff   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++;
        if (out_data !== 16'd0) begin failures++; $display("FAIL reset_out got=%0d want=0", out_data); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0]      va [6];
        logic [CBITS-1:0] vc [6];
        int               ve [6];
        logic [15:0]      res;
        int               lat, bcnt;
        va[0] = 16'd100;   vc[0] = 8'h80; ve[0] = 50;
        va[1] = -16'sd7;   vc[1] = 8'h80; ve[1] = -4;
        va[2] = 16'd1000;  vc[2] = 8'hC0; ve[2] = 750;
        va[3] = 16'h8000;  vc[3] = 8'hFF; ve[3] = -32640;
        va[4] = 16'd3;     vc[4] = 8'hFF; ve[4] = 1;
        va[5] = 16'd12345; vc[5] = 8'h00; ve[5] = 0;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vc[i], res, lat, bcnt);
            checks++;
            if (int'($signed(res)) !== ve[i]) begin
                failures++;
                $display("FAIL directed_%0d_result got=%0d want=%0d", i, $signed(res), ve[i]);
            end
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat, LAT);
            end
            checks++;
            if (bcnt !== CBITS) begin
                failures++;
                $display("FAIL directed_%0d_busy_cycles got=%0d want=%0d", i, bcnt, CBITS);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL directed_%0d_done_pulse got=%b want=0", i, done);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (int'($signed(out_data)) !== ve[5]) begin
            failures++;
            $display("FAIL out_hold got=%0d want=%0d", $signed(out_data), ve[5]);
        end
    endtask

    task automatic test_random();
        logic [15:0]      a, res;
        logic [CBITS-1:0] c;
        int               lat, bcnt, exp;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            c = CBITS'($urandom);
            exp = model(int'($signed(a)), int'(c));
            do_op(a, c, res, lat, bcnt);
            checks++;
            if (int'($signed(res)) !== exp || lat !== LAT) begin
                failures++;
                $display("FAIL random_%0d in=%0d coeff=%h got=%0d lat=%0d want=%0d lat=%0d",
                         i, $signed(a), c, $signed(res), lat, exp, LAT);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat, exp;
        logic [15:0] res;
        exp = model(-1234, 8'hA5);
        @(negedge clk);
        in_data = -16'sd1234;
        coeff   = 8'hA5;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        res = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                in_data = 16'd7777;
                coeff   = 8'hFF;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                res = out_data;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (int'($signed(res)) !== exp) begin
            failures++;
            $display("FAIL ignore_start_result got=%0d want=%0d", $signed(res), exp);
        end
        checks++;
        if (lat !== LAT) begin
            failures++;
            $display("FAIL ignore_start_latency got=%0d want=%0d", lat, LAT);
        end
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_queued busy=%b done=%b want busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] res1, res2;
        int lat1, lat2, bcnt;
        do_op(16'd20000, 8'h55, res1, lat1, bcnt);
        // Still in the DONE cycle: request the next operation right away.
        in_data = -16'sd20000;
        coeff   = 8'hE3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat2 = 0;
        res2 = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat2 = k;
                res2 = out_data;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (int'($signed(res1)) !== model(20000, 8'h55)) begin
            failures++;
            $display("FAIL b2b_first got=%0d want=%0d", $signed(res1), model(20000, 8'h55));
        end
        checks++;
        if (int'($signed(res2)) !== model(-20000, 8'hE3) || lat2 !== LAT) begin
            failures++;
            $display("FAIL b2b_second got=%0d lat=%0d want=%0d lat=%0d",
                     $signed(res2), lat2, model(-20000, 8'hE3), LAT);
        end
    endtask

    task automatic test_reset_abort();
        int seen_done;
        logic [15:0] res;
        int lat, bcnt;
        @(negedge clk);
        in_data = 16'd30000;
        coeff   = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_data !== 16'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_state busy=%b done=%b out=%0d want 0 0 0", busy, done, out_data);
        end
        seen_done = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) seen_done = 1;
            @(negedge clk);
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d want=0", seen_done);
        end
        do_op(16'd30000, 8'hFF, res, lat, bcnt);
        checks++;
        if (int'($signed(res)) !== model(30000, 8'hFF) || lat !== LAT) begin
            failures++;
            $display("FAIL abort_restart got=%0d lat=%0d want=%0d lat=%0d",
                     $signed(res), lat, model(30000, 8'hFF), LAT);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_data  = '0;
        coeff    = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
